// File: rtl/shift_add_pkg.sv
// Shared definitions for the shift-and-add multiplier: FSM state encoding
// and the default operand width.
package shift_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 4;

endpackage : shift_add_pkg

// File: rtl/ripple_carry_adder.sv
// WIDTH-bit ripple-carry adder built from a chain of full adders; the
// carry-out is exported so the multiplier never loses the top partial bit.
module ripple_carry_adder #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] S,
    output logic             Cout
);

    logic [WIDTH:0] carry_s;

    assign carry_s[0] = Cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign S[i]           = A[i] ^ B[i] ^ carry_s[i];
        assign carry_s[i + 1] = (A[i] & B[i]) | (carry_s[i] & (A[i] ^ B[i]));
    end

    assign Cout = carry_s[WIDTH];

endmodule : ripple_carry_adder

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned multiplier: one conditional add-and-shift per cycle,
// WIDTH iterations, then a one-cycle done pulse with the registered product.
module shift_add_multiplier
    import shift_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] P
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   p_q, p_d;
    logic                 done_q, done_d;
    logic                 busy_q, busy_d;

    logic [WIDTH-1:0]     addend_s;
    logic [WIDTH-1:0]     sum_s;
    logic                 cout_s;
    logic [2*WIDTH:0]     wide_s;
    logic [2*WIDTH-1:0]   shifted_s;

    assign addend_s = mcand_q & {WIDTH{mplier_q[0]}};

    ripple_carry_adder #(
        .WIDTH (WIDTH)
    ) u_adder (
        .A    (acc_q[2*WIDTH-1:WIDTH]),
        .B    (addend_s),
        .Cin  (1'b0),
        .S    (sum_s),
        .Cout (cout_s)
    );

    // The carry-out becomes the new MSB, so the full 2*WIDTH+1-bit partial
    // result survives the shift and no product bit can be dropped.
    assign wide_s    = {cout_s, sum_s, acc_q[WIDTH-1:0]};
    assign shifted_s = (2*WIDTH)'(wide_s >> 1);

    // Next-state and datapath update for the IDLE/RUN/DONE sequence
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        p_d      = p_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = RUN;
                    mcand_d  = A;
                    mplier_d = B;
                    acc_d    = '0;
                    cnt_d    = '0;
                end else begin
                    state_d  = IDLE;
                end
            end
            RUN: begin
                acc_d    = shifted_s;
                mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d = DONE;
                    p_d     = shifted_s;
                    done_d  = 1'b1;
                end else begin
                    state_d = RUN;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            p_q      <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            p_q      <= p_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign P    = p_q;

endmodule : shift_add_multiplier

// File: tb/tb_shift_add_multiplier.sv
// Scoreboard bench for shift_add_multiplier (WIDTH=4): stimulus pushes the
// expected product, a negedge monitor pops it whenever done is seen.
module tb_shift_add_multiplier;

    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [W-1:0]   A;
    logic [W-1:0]   B;
    logic           busy;
    logic           done;
    logic [2*W-1:0] P;

    int checks      = 0;
    int failures    = 0;
    int done_count  = 0;

    logic [2*W-1:0] exp_q[$];
    logic [2*W-1:0] mon_exp;

    always #5 clk = ~clk;

    shift_add_multiplier #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .P     (P)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest pending product
    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_count++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_done: P=%0d with no product pending", P);
            end else begin
                mon_exp = exp_q.pop_front();
                if (P !== mon_exp) begin
                    failures++;
                    $display("FAIL product: got %0d expected %0d", P, mon_exp);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 50) begin
            tick();
            n++;
        end
        check("idle_wait", (n < 50) ? 1 : 0, 1);
    endtask

    task automatic run_op(input int a, input int b);
        A     = W'(a);
        B     = W'(b);
        start = 1'b1;
        exp_q.push_back((2*W)'(a * b));
        tick();
        start = 1'b0;
        wait_idle();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bc;
        int di;
        int d0;
        int n;
        int cyc;
        int didx[3];

        rst   = 1'b1;
        start = 1'b0;
        A     = '0;
        B     = '0;
        tick();
        tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_P", P, 0);
        rst = 1'b0;
        tick();
        check("idle_busy", busy, 0);

        // 6*7 = 42, busy for 5 cycles, done in the 5th cycle after accept
        A = 4'd6; B = 4'd7; start = 1'b1;
        exp_q.push_back(8'd42);
        tick();
        start = 1'b0; A = '0; B = '0;
        bc = 0; di = -1;
        for (int i = 0; i < 12; i++) begin
            if (busy === 1'b1) bc++;
            if (done === 1'b1 && di < 0) di = i;
            tick();
        end
        check("busy_cycles", bc, 5);
        check("done_latency", di, 4);
        check("p_hold_idle", P, 42);

        d0 = done_count;
        run_op(15, 15);
        run_op(0, 10);
        run_op(10, 0);
        check("three_done_pulses", done_count - d0, 3);
        check("zero_product", P, 0);

        // P must keep the previous product while the next one runs
        A = 4'd2; B = 4'd3; start = 1'b1;
        exp_q.push_back(8'd6);
        tick();
        start = 1'b0;
        tick();
        check("p_hold_run", P, 0);
        wait_idle();
        check("p_after_2x3", P, 6);

        // start and operand changes during RUN are ignored
        d0 = done_count;
        A = 4'd5; B = 4'd3; start = 1'b1;
        exp_q.push_back(8'd15);
        tick();
        start = 1'b0;
        tick();
        start = 1'b1; A = 4'd15; B = 4'd15;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0; A = '0; B = '0;
        wait_idle();
        repeat (4) tick();
        check("run_ignore_pulses", done_count - d0, 1);
        check("run_ignore_P", P, 15);

        // reset on the 2nd RUN cycle abandons the multiply
        d0 = done_count;
        A = 4'd9; B = 4'd9; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_P", P, 0);
        repeat (10) tick();
        check("abort_no_done", done_count - d0, 0);

        // start held high: one product every 6 cycles
        d0 = done_count;
        A = 4'd3; B = 4'd5; start = 1'b1;
        repeat (3) exp_q.push_back(8'd15);
        n = 0; cyc = 0;
        while (n < 3 && cyc < 60) begin
            tick();
            cyc++;
            if (done === 1'b1) begin
                didx[n] = cyc;
                n++;
            end
        end
        start = 1'b0;
        check("held_done_seen", n, 3);
        if (n == 3) begin
            check("held_period_1", didx[1] - didx[0], 6);
            check("held_period_2", didx[2] - didx[1], 6);
        end
        wait_idle();
        repeat (8) tick();
        check("held_done_count", done_count - d0, 3);

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                run_op(a, b);
            end
        end
        check("final_P", P, 225);

        repeat (3) tick();
        check("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_shift_add_multiplier
